// File: rtl/serial_chunk_adder_pkg.sv
// Shared definitions for serial_chunk_adder: FSM state encodings and chunk-count helper.
package serial_chunk_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index register needs at least one bit even when a single chunk covers the word.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/ripple_adder_n.sv
// CHUNK-bit combinational ripple adder built from a chain of full-adder cells.
module ripple_adder_n #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout    = carry[CHUNK];
  // Carry into the top bit; XOR with cout gives signed overflow.
  assign msb_cin = carry[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle add/subtract unit processing CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
  localparam int IDXW   = idx_width(NCHUNK);

  state_t           state_q, state_d;
  logic             accept;
  logic [WIDTH-1:0] a_q, b_q, psum_q, psum_d;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             last_chunk;
  int               offset;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_chunk;

  always_comb begin
    offset  = int'(idx_q) * CHUNK;
    a_chunk = a_q[offset +: CHUNK];
    b_chunk = b_q[offset +: CHUNK];
    psum_d  = psum_q;
    psum_d[offset +: CHUNK] = s_chunk;
  end

  assign last_chunk = (idx_q == IDXW'(NCHUNK - 1));

`ifdef SERIAL_ADDER_OVF_EN
  logic msb_cin;
  logic ovf_q;

  ripple_adder_n #(.CHUNK(CHUNK)) u_adder (
    .a       (a_chunk),
    .b       (b_chunk),
    .cin     (carry_q),
    .sum     (s_chunk),
    .cout    (c_chunk),
    .msb_cin (msb_cin)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (state_q == ST_RUN && last_chunk) begin
      ovf_q <= msb_cin ^ c_chunk;
    end
  end

  assign ovf = ovf_q;
`else
  ripple_adder_n #(.CHUNK(CHUNK)) u_adder (
    .a       (a_chunk),
    .b       (b_chunk),
    .cin     (carry_q),
    .sum     (s_chunk),
    .cout    (c_chunk),
    .msb_cin ()
  );
`endif

  // A start in DONE is accepted immediately so back-to-back operations lose no cycle.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_chunk) state_d = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        // Subtraction is A + ~B + 1, so B is inverted once at capture.
        a_q     <= a;
        b_q     <= sub ? ~b : b;
        carry_q <= sub ? 1'b1 : cin;
        idx_q   <= '0;
      end else if (state_q == ST_RUN) begin
        psum_q  <= psum_d;
        carry_q <= c_chunk;
        idx_q   <= idx_q + 1'b1;
        if (last_chunk) begin
          sum_q  <= psum_d;
          cout_q <= c_chunk;
        end
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
